dec_error_correct: RTL

Registered correction stage directly downstream of the decoder's syndrome column matcher (`dec_is_column`). It consumes the codeword data, syndrome, `isCol` and `whatCol`, and classifies each word as clean, single-error or multi-error. It flips the located data bit when the error is correctable and hands the result on through a valid/ready pipeline register. It optionally keeps saturating error statistics.

---
 rtl/dec_pkg.sv | 27 ++
 rtl/dec_err_classify.sv | 67 ++++++
 rtl/dec_error_correct.sv | 117 +++++++++++
 3 files changed

// File: rtl/dec_pkg.sv
// Shared types for the decoder correction stage: codeword width, error class and
// the syndrome parity-bit position for each width.
package dec_pkg;

  typedef enum logic [1:0] {
    W8  = 2'b00,
    W16 = 2'b01,
    W32 = 2'b10
  } width_e;

  typedef enum logic [1:0] {
    NO_ERR     = 2'd0,
    SINGLE_ERR = 2'd1,
    MULTI_ERR  = 2'd2
  } nerr_e;

  // Any width code with bit 1 set selects the 32-bit layout.
  function automatic logic [2:0] parity_idx(input logic [1:0] cw);
    if (cw[1]) begin
      return 3'd5;
    end else if (cw[0]) begin
      return 3'd4;
    end
    return 3'd3;
  endfunction

endpackage

// File: rtl/dec_err_classify.sv
// Combinational syndrome classifier: masks data to the active width, flips the
// located bit when a single data-bit error is correctable, and reports the error class.
module dec_err_classify
  import dec_pkg::*;
(
  input  logic [31:0] data_in,
  input  logic [5:0]  s,
  input  logic [1:0]  codeword_width,
  input  logic        isCol,
  input  logic [4:0]  whatCol,
  output logic [31:0] data_out,
  output nerr_e       num_of_errors
);

  logic [2:0]  pidx;
  logic [5:0]  low_mask;
  logic [5:0]  sl;
  logic        parity;
  logic        col_ok;
  logic [31:0] dmask;
  logic [31:0] flip;

  always_comb begin
    pidx          = parity_idx(codeword_width);
    low_mask      = (6'd1 << pidx) - 6'd1;
    sl            = s & low_mask;
    parity        = s[pidx];
    dmask         = 32'hFFFF_FFFF;
    col_ok        = 1'b1;
    flip          = '0;
    num_of_errors = NO_ERR;

    case (codeword_width)
      W8: begin
        dmask  = 32'h0000_00FF;
        col_ok = (whatCol < 5'd8);
      end
      W16: begin
        dmask  = 32'h0000_FFFF;
        col_ok = (whatCol < 5'd16);
      end
      default: begin
        dmask  = 32'hFFFF_FFFF;
        col_ok = 1'b1;
      end
    endcase

    if (parity || (sl != '0)) begin
      if (parity && isCol) begin
        // A column outside the active data width cannot be corrected.
        if (col_ok) begin
          num_of_errors = SINGLE_ERR;
          flip          = 32'd1 << whatCol;
        end else begin
          num_of_errors = MULTI_ERR;
        end
      end else if (parity && $onehot0(sl)) begin
        num_of_errors = SINGLE_ERR;
      end else begin
        num_of_errors = MULTI_ERR;
      end
    end

    data_out = (data_in & dmask) ^ flip;
  end

endmodule

// File: rtl/dec_error_correct.sv
// Registered error-correction stage, 1-cycle latency; in_ready = !out_valid || out_ready, output held under stall.
// DEC_ERR_STATS_EN builds saturating single/double error counters with a synchronous clear.
module dec_error_correct
  import dec_pkg::*;
#(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        data_in,
  input  logic [5:0]         s,
  input  logic [1:0]         codeword_width,
  input  logic               isCol,
  input  logic [4:0]         whatCol,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        data_out,
  output logic [1:0]         num_of_errors,
  input  logic               stat_clr,
  output logic [COUNT_W-1:0] single_cnt,
  output logic [COUNT_W-1:0] double_cnt
);

  logic        out_valid_q, out_valid_d;
  logic [31:0] data_q, data_d;
  nerr_e       nerr_q, nerr_d;
  logic [31:0] cls_data;
  nerr_e       cls_nerr;
  logic        in_xfer;
  logic        out_xfer;

  dec_err_classify u_classify (
    .data_in        (data_in),
    .s              (s),
    .codeword_width (codeword_width),
    .isCol          (isCol),
    .whatCol        (whatCol),
    .data_out       (cls_data),
    .num_of_errors  (cls_nerr)
  );

  assign in_ready = !out_valid_q || out_ready;
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid_q && out_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    data_d      = data_q;
    nerr_d      = nerr_q;
    if (in_xfer) begin
      out_valid_d = 1'b1;
      data_d      = cls_data;
      nerr_d      = cls_nerr;
    end else if (out_xfer) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      data_q      <= '0;
      nerr_q      <= NO_ERR;
    end else begin
      out_valid_q <= out_valid_d;
      data_q      <= data_d;
      nerr_q      <= nerr_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign data_out      = data_q;
  assign num_of_errors = nerr_q;

`ifdef DEC_ERR_STATS_EN
  logic [COUNT_W-1:0] single_cnt_q, single_cnt_d;
  logic [COUNT_W-1:0] double_cnt_q, double_cnt_d;

  // Clear wins over a same-cycle increment; counts stick at all-ones.
  always_comb begin
    single_cnt_d = single_cnt_q;
    double_cnt_d = double_cnt_q;
    if (stat_clr) begin
      single_cnt_d = '0;
      double_cnt_d = '0;
    end else if (out_xfer) begin
      if ((nerr_q == SINGLE_ERR) && (single_cnt_q != '1)) begin
        single_cnt_d = single_cnt_q + 1'b1;
      end
      if ((nerr_q == MULTI_ERR) && (double_cnt_q != '1)) begin
        double_cnt_d = double_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      single_cnt_q <= '0;
      double_cnt_q <= '0;
    end else begin
      single_cnt_q <= single_cnt_d;
      double_cnt_q <= double_cnt_d;
    end
  end

  assign single_cnt = single_cnt_q;
  assign double_cnt = double_cnt_q;
`else
  logic stat_clr_unused;
  assign stat_clr_unused = stat_clr;
  assign single_cnt      = '0;
  assign double_cnt      = '0;
`endif

endmodule
